// File: rtl/multicycle_core.sv
// Multi-cycle FETCH/DECODE/EXEC core: 16-bit instructions over a req/valid fetch port,
// parametrised data/PC width and register count, with HALT and sticky illegal-opcode flag.
module multicycle_core #(
  parameter int DATA_W   = 8,
  parameter int PC_W     = 8,
  parameter int NUM_REGS = 4
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [15:0]       imem_data,
  input  logic              imem_valid,
  output logic              retire,
  output logic              wb_en,
  output logic [3:0]        wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              halted,
  output logic              illegal
);
  localparam int RIDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic [1:0] {S_FETCH, S_DECODE, S_EXEC, S_HALT} state_t;

  state_t             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [15:0]        ir_q, ir_d;
  logic [DATA_W-1:0]  regs_q [NUM_REGS];
  logic [DATA_W-1:0]  regs_d [NUM_REGS];
  logic [DATA_W-1:0]  rs1v_q, rs1v_d, rs2v_q, rs2v_d, rdv_q, rdv_d, imm_q, imm_d;
  logic [PC_W-1:0]    off_q, off_d;
  logic               illegal_q, illegal_d;

  logic [3:0]         op;
  logic [RIDX_W-1:0]  rd_idx, rs1_idx, rs2_idx;
  logic [DATA_W-1:0]  alu;
  logic               wr;
  logic [PC_W-1:0]    pc_nxt;
  logic               unused_ir;

  always_comb begin
    op        = ir_q[15:12];
    rd_idx    = ir_q[8 +: RIDX_W];
    rs1_idx   = ir_q[4 +: RIDX_W];
    rs2_idx   = ir_q[0 +: RIDX_W];
    unused_ir = ^ir_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      pc_q      <= '0;
      ir_q      <= '0;
      regs_q    <= '{default: '0};
      rs1v_q    <= '0;
      rs2v_q    <= '0;
      rdv_q     <= '0;
      imm_q     <= '0;
      off_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      regs_q    <= regs_d;
      rs1v_q    <= rs1v_d;
      rs2v_q    <= rs2v_d;
      rdv_q     <= rdv_d;
      imm_q     <= imm_d;
      off_q     <= off_d;
      illegal_q <= illegal_d;
    end
  end

  // Execute-stage datapath: ALU result, write enable and successor pc
  always_comb begin
    alu    = '0;
    wr     = 1'b0;
    pc_nxt = pc_q + PC_W'(1);
    unique case (op)
      4'h1: begin alu = rs1v_q + rs2v_q; wr = 1'b1; end
      4'h2: begin alu = rs1v_q - rs2v_q; wr = 1'b1; end
      4'h3: begin alu = rs1v_q & rs2v_q; wr = 1'b1; end
      4'h4: begin alu = rs1v_q | rs2v_q; wr = 1'b1; end
      4'h5: begin alu = rs1v_q ^ rs2v_q; wr = 1'b1; end
      4'h6: begin alu = imm_q;           wr = 1'b1; end
      4'h7: begin alu = rdv_q + imm_q;   wr = 1'b1; end
      4'h8: if (rdv_q == '0) pc_nxt = pc_q + off_q;
      4'h9: pc_nxt = pc_q + off_q;
      4'hF: pc_nxt = pc_q;
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    regs_d    = regs_q;
    rs1v_d    = rs1v_q;
    rs2v_d    = rs2v_q;
    rdv_d     = rdv_q;
    imm_d     = imm_q;
    off_d     = off_q;
    illegal_d = illegal_q;
    unique case (state_q)
      S_FETCH: if (imem_valid) begin
        ir_d    = imem_data;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        rs1v_d  = (rs1_idx == '0) ? '0 : regs_q[rs1_idx];
        rs2v_d  = (rs2_idx == '0) ? '0 : regs_q[rs2_idx];
        rdv_d   = (rd_idx  == '0) ? '0 : regs_q[rd_idx];
        imm_d   = DATA_W'($signed(ir_q[7:0]));
        off_d   = PC_W'($signed(ir_q[7:0]));
        state_d = S_EXEC;
      end
      S_EXEC: begin
        pc_d = pc_nxt;
        if (wr && rd_idx != '0) regs_d[rd_idx] = alu;
        if (op >= 4'hA && op <= 4'hE) illegal_d = 1'b1;
        state_d = (op == 4'hF) ? S_HALT : S_FETCH;
      end
      S_HALT: ;
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    imem_req  = (state_q == S_FETCH);
    imem_addr = pc_q;
    retire    = (state_q == S_EXEC);
    wb_en     = retire && wr;
    wb_addr   = wb_en ? 4'(rd_idx) : '0;
    wb_data   = wb_en ? alu : '0;
    halted    = (state_q == S_HALT);
    illegal   = illegal_q;
  end

endmodule

// File: tb/tb_multicycle_core.sv
// Self-checking bench for multicycle_core (PC_W=4): directed ALU vectors, branch/wrap,
// wait-state, r0/illegal, HALT/reset sequences, plus random programs against an ISA model.
module tb_multicycle_core;
  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [3:0]  imem_addr;
  logic [15:0] imem_data;
  logic        imem_valid;
  logic        retire, wb_en, halted, illegal;
  logic [3:0]  wb_addr;
  logic [7:0]  wb_data;

  logic [15:0] mem [16];
  assign imem_data = mem[imem_addr];

  multicycle_core #(.DATA_W(8), .PC_W(4), .NUM_REGS(4)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_data(imem_data), .imem_valid(imem_valid), .retire(retire), .wb_en(wb_en),
    .wb_addr(wb_addr), .wb_data(wb_data), .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // ISA-level reference state
  logic [7:0] m_regs [4];
  int         m_pc;
  bit         m_illegal, m_halted;
  logic [7:0] last_wb_data;
  int         last_pc, last_cycles;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int wrap16(input int x);
    return ((x % 16) + 16) % 16;
  endfunction

  task automatic model_reset();
    foreach (m_regs[i]) m_regs[i] = 8'h00;
    m_pc = 0; m_illegal = 0; m_halted = 0;
  endtask

  task automatic clear_mem();
    foreach (mem[i]) mem[i] = 16'h0000;
  endtask

  task automatic do_reset(input int n);
    imem_valid = 1'b1;
    reset = 1'b1;
    repeat (n) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic predict(output bit en, output int addr, output logic [7:0] data,
                         output int npc, output bit halt, output bit ill);
    logic [15:0] ins;
    int op, rd, simm;
    logic [7:0] a, b, d;
    ins  = mem[m_pc];
    op   = int'(ins[15:12]);
    rd   = int'(ins[9:8]);
    a    = m_regs[ins[5:4]];
    b    = m_regs[ins[1:0]];
    d    = m_regs[rd];
    simm = ins[7] ? int'(ins[7:0]) - 256 : int'(ins[7:0]);
    en = 0; addr = rd; data = 8'h00; npc = wrap16(m_pc + 1); halt = 0;
    ill = (op >= 10 && op <= 14);
    case (op)
      1: begin en = 1; data = a + b; end
      2: begin en = 1; data = a - b; end
      3: begin en = 1; data = a & b; end
      4: begin en = 1; data = a | b; end
      5: begin en = 1; data = a ^ b; end
      6: begin en = 1; data = 8'(simm); end
      7: begin en = 1; data = d + 8'(simm); end
      8: if (d == 8'h00) npc = wrap16(m_pc + simm);
      9: npc = wrap16(m_pc + simm);
      15: begin halt = 1; npc = m_pc; end
      default: ;
    endcase
  endtask

  // Runs one instruction from a FETCH-cycle negedge to the next instruction's FETCH negedge.
  task automatic run_instr(input int wait_pct, input int fixed_waits);
    bit e_en, e_halt, e_ill, done, stall;
    int e_addr, e_npc, waits, cyc;
    logic [7:0] e_data;
    predict(e_en, e_addr, e_data, e_npc, e_halt, e_ill);
    waits = 0; cyc = 0; done = 0;
    while (!done && cyc < 64) begin
      if (imem_req) begin
        check("fetch_addr", imem_addr, m_pc);
        stall = (fixed_waits >= 0) ? (waits < fixed_waits) : (int'($urandom_range(99)) < wait_pct);
        if (stall) begin imem_valid = 1'b0; waits++; end
        else imem_valid = 1'b1;
      end else begin
        imem_valid = 1'($urandom_range(1));
      end
      @(negedge clk);
      cyc++;
      if (retire) done = 1;
      else check("no_early_wb", wb_en, 0);
    end
    if (!done) begin
      check("retire_timeout", 0, 1);
      return;
    end
    last_cycles = cyc + 1;
    check("latency", cyc + 1, 3 + waits);
    check("wb_en", wb_en, e_en);
    if (e_en) check("wb_addr", wb_addr, e_addr);
    if (e_en && e_addr != 0) check("wb_data", wb_data, e_data);
    last_wb_data = wb_data;
    if (e_en && e_addr != 0) m_regs[e_addr] = e_data;
    if (e_ill) m_illegal = 1;
    m_pc = e_npc;
    m_halted = e_halt;
    @(negedge clk);
    check("illegal", illegal, m_illegal);
    check("halted", halted, m_halted);
    check("req_after", imem_req, !m_halted);
    if (!m_halted) check("next_addr", imem_addr, m_pc);
    last_pc = imem_addr;
  endtask

  initial begin
    int exp_pcs [6];
    vecs[0] = '{4'h1, 8'h7F, 8'h02, 8'h81};
    vecs[1] = '{4'h2, 8'h02, 8'h7F, 8'h83};
    vecs[2] = '{4'h5, 8'h7F, 8'h7F, 8'h00};
    vecs[3] = '{4'h3, 8'hF0, 8'h3C, 8'h30};
    vecs[4] = '{4'h4, 8'hF0, 8'h0F, 8'hFF};
    vecs[5] = '{4'h1, 8'hFF, 8'h01, 8'h00};
    vecs[6] = '{4'h7, 8'h10, 8'h20, 8'h12};
    exp_pcs = '{1, 5, 3, 4, 15, 0};
    reset = 1'b1;
    imem_valid = 1'b1;

    // Reset with imem_valid high, then LI r1,5
    clear_mem();
    mem[0] = 16'h6105;
    do_reset(2);
    check("rst_req", imem_req, 1);
    check("rst_addr", imem_addr, 0);
    check("rst_outs", {retire, wb_en, wb_addr, wb_data, halted, illegal}, 0);
    run_instr(0, 0);
    check("li_r1_5", last_wb_data, 8'h05);

    // ALU table: LI r1,a; LI r2,b; op r3,r1,r2 (imm8 0x12)
    for (int i = 0; i < 7; i++) begin
      clear_mem();
      mem[0] = {8'h61, vecs[i].a};
      mem[1] = {8'h62, vecs[i].b};
      mem[2] = {vecs[i].op, 12'h312};
      mem[3] = 16'hF000;
      do_reset(1);
      repeat (3) run_instr(0, 0);
      check("alu_vec", last_wb_data, vecs[i].exp);
    end

    // Wait states: 4 stalled fetch cycles
    clear_mem();
    mem[0] = 16'h6105;
    mem[1] = 16'h1211;
    do_reset(1);
    run_instr(0, 0);
    run_instr(0, 4);
    check("wait_latency", last_cycles, 7);
    check("wait_data", last_wb_data, 8'h0A);

    // Branches and pc wrap
    clear_mem();
    mem[0]  = 16'h6101;
    mem[1]  = 16'h9004;
    mem[5]  = 16'h80FE;
    mem[3]  = 16'h8107;
    mem[4]  = 16'h90FB;
    mem[15] = 16'h9001;
    do_reset(1);
    for (int i = 0; i < 6; i++) begin
      run_instr(20, -1);
      check("branch_pc", last_pc, exp_pcs[i]);
    end

    // JMP 0 self-loop
    clear_mem();
    mem[0] = 16'h9000;
    do_reset(1);
    repeat (2) run_instr(0, 0);
    check("jmp0_pc", last_pc, 0);

    // r0 writes dropped, illegal opcode, HALT at pc=6
    clear_mem();
    mem[0] = 16'h6009;
    mem[1] = 16'h1100;
    mem[2] = 16'hC000;
    mem[3] = 16'h0000;
    mem[4] = 16'h71FF;
    mem[5] = 16'h0000;
    mem[6] = 16'hF000;
    do_reset(1);
    run_instr(0, 0);
    check("r0_wb_addr", last_pc, 1);
    run_instr(0, 0);
    check("r0_reads_zero", last_wb_data, 8'h00);
    run_instr(0, 0);
    check("illegal_set", illegal, 1);
    check("illegal_pc", last_pc, 3);
    run_instr(0, 0);
    check("illegal_sticky", illegal, 1);
    repeat (3) run_instr(0, 0);
    check("halt_flag", halted, 1);
    for (int i = 0; i < 8; i++) begin
      imem_valid = 1'($urandom_range(1));
      @(negedge clk);
      check("halt_hold", {halted, imem_req, retire, wb_en}, 4'b1000);
      check("halt_pc", imem_addr, 6);
    end

    // Reset during DECODE of ADD r2,r1,r1 aborts it; restart sees cleared registers
    clear_mem();
    mem[0] = 16'h1211;
    mem[1] = 16'h6144;
    mem[2] = 16'h90FE;
    do_reset(1);
    repeat (3) run_instr(0, 0);
    imem_valid = 1'b1;
    @(negedge clk);
    check("dec_no_req", imem_req, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    check("abort_no_wb", {retire, wb_en}, 2'b00);
    check("abort_addr", {imem_req, imem_addr}, 5'b10000);
    run_instr(0, 0);
    check("regs_cleared", last_wb_data, 8'h00);

    // Random programs with random wait states
    for (int r = 0; r < 5; r++) begin
      foreach (mem[i]) mem[i] = 16'($urandom);
      do_reset(1);
      for (int n = 0; n < 30; n++) begin
        if (m_halted) break;
        run_instr(30, -1);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
